// File: rtl/piezo_pkg.sv
// Shared types and default configuration for the piezo alert sequencer.
package piezo_pkg;

  // Cadence FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } state_e;

  localparam int unsigned NAlertDefault = 3;
  localparam int unsigned HpWDefault    = 16;
  localparam int unsigned CadWDefault   = 27;

  // Alert index for the default channel count.
  typedef logic [$clog2(NAlertDefault)-1:0] idx_t;

  // Leftmost field is alert 0 (highest priority).
  localparam logic [NAlertDefault*HpWDefault-1:0] DefToneHp =
    {16'd4096, 16'd8192, 16'd8192};
  localparam logic [NAlertDefault*CadWDefault-1:0] DefOnCyc =
    {27'd12_500_000, 27'd25_000_000, 27'd50_000_000};
  localparam logic [NAlertDefault*CadWDefault-1:0] DefOffCyc =
    {27'd12_500_000, 27'd0, 27'd50_000_000};

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave tone generator with programmable half-period.
// The tone output is the level the tone takes after the coming clock edge,
// so the caller can register it straight into its output flop.
module piezo_tone_gen #(
  parameter int unsigned HP_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [HP_W-1:0] half_period,
  input  logic            restart,
  input  logic            enable,
  output logic            tone
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            tone_q, tone_d;

  // Restart forces a fresh high half-period; enable advances the counter.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (restart) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == half_period - HP_W'(1)) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + HP_W'(1);
      end
    end
  end

  // Tone counter and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_d;

endmodule

// File: rtl/piezo_alert_seq.sv
// Prioritised multi-alert piezo sequencer: arbitrates alert requests, runs
// the on/off cadence of the selected alert and drives a differential pair.
// Optional mute masking is built when PIEZO_MUTE_EN is defined.
module piezo_alert_seq
  import piezo_pkg::*;
#(
  parameter int unsigned                   N_ALERT = NAlertDefault,
  parameter int unsigned                   HP_W    = HpWDefault,
  parameter int unsigned                   CAD_W   = CadWDefault,
  parameter logic [N_ALERT*HP_W-1:0]       TONE_HP = DefToneHp,
  parameter logic [N_ALERT*CAD_W-1:0]      ON_CYC  = DefOnCyc,
  parameter logic [N_ALERT*CAD_W-1:0]      OFF_CYC = DefOffCyc
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ALERT-1:0]         alert_req,
`ifdef PIEZO_MUTE_EN
  input  logic                       mute,
`endif
  output logic                       piezo,
  output logic                       piezo_n,
  output logic [$clog2(N_ALERT)-1:0] active_idx,
  output logic                       busy
);

  localparam int unsigned IdxW = $clog2(N_ALERT);

  logic [HP_W-1:0]  hp_arr  [N_ALERT];
  logic [CAD_W-1:0] on_arr  [N_ALERT];
  logic [CAD_W-1:0] off_arr [N_ALERT];

  if (N_ALERT < 2) begin : gen_bad_n
    $error("piezo_alert_seq: N_ALERT must be at least 2");
  end

  // Unpack per-alert configuration; field 0 is the leftmost.
  for (genvar i = 0; i < N_ALERT; i++) begin : gen_cfg
    localparam int unsigned Pos = N_ALERT - 1 - i;
    assign hp_arr[i]  = TONE_HP[Pos*HP_W +: HP_W];
    assign on_arr[i]  = ON_CYC[Pos*CAD_W +: CAD_W];
    assign off_arr[i] = OFF_CYC[Pos*CAD_W +: CAD_W];
    if (TONE_HP[Pos*HP_W +: HP_W] == '0) begin : gen_bad_hp
      $error("piezo_alert_seq: TONE_HP entry must be at least 1");
    end
    if (ON_CYC[Pos*CAD_W +: CAD_W] == '0) begin : gen_bad_on
      $error("piezo_alert_seq: ON_CYC entry must be at least 1");
    end
  end

  state_e           state_q, state_d;
  logic [IdxW-1:0]  sel_q, sel_d;
  logic [CAD_W-1:0] cad_cnt_q, cad_cnt_d;
  logic             piezo_q, piezo_n_q, piezo_d;
  logic [N_ALERT-1:0] req_eff;
  logic             run_masked;
  logic             any_req, preempt, rearb, load;
  logic [IdxW-1:0]  low_idx;
  logic             tone;

`ifdef PIEZO_MUTE_EN
  logic [N_ALERT-1:0] mask_q, mask_d, mute_set;

  // A mute pulse masks the running alert; a low request clears its mask.
  always_comb begin
    mute_set = '0;
    if (mute && (state_q != StIdle)) begin
      mute_set[sel_q] = 1'b1;
    end
    mask_d = (mask_q & alert_req) | mute_set;
  end

  // Mute mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign req_eff    = alert_req & ~mask_d;
  assign run_masked = (state_q != StIdle) && mask_d[sel_q];
`else
  assign req_eff    = alert_req;
  assign run_masked = 1'b0;
`endif

  // Priority encode and detect higher-priority requests than the running one.
  always_comb begin
    any_req = 1'b0;
    low_idx = '0;
    preempt = 1'b0;
    for (int i = int'(N_ALERT) - 1; i >= 0; i--) begin
      if (req_eff[i]) begin
        any_req = 1'b1;
        low_idx = IdxW'(i);
      end
    end
    for (int i = 0; i < int'(N_ALERT); i++) begin
      if ((i < int'(sel_q)) && req_eff[i]) begin
        preempt = 1'b1;
      end
    end
  end

  // Cadence FSM next state; preemption outranks the normal cadence exit.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cad_cnt_d = cad_cnt_q + CAD_W'(1);
    rearb     = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cad_cnt_d = '0;
        rearb     = 1'b1;
      end
      StOn: begin
        if (preempt || run_masked) begin
          rearb = 1'b1;
        end else if (cad_cnt_q == on_arr[sel_q] - CAD_W'(1)) begin
          if (off_arr[sel_q] == '0) begin
            rearb = 1'b1;
          end else begin
            state_d   = StOff;
            cad_cnt_d = '0;
          end
        end
      end
      StOff: begin
        if (preempt || run_masked) begin
          rearb = 1'b1;
        end else if (cad_cnt_q == off_arr[sel_q] - CAD_W'(1)) begin
          rearb = 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        cad_cnt_d = '0;
      end
    endcase
    if (rearb) begin
      cad_cnt_d = '0;
      if (any_req) begin
        state_d = StOn;
        sel_d   = low_idx;
        load    = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  piezo_tone_gen #(
    .HP_W (HP_W)
  ) u_tone (
    .clk         (clk),
    .rst         (rst),
    .half_period (hp_arr[sel_q]),
    .restart     (load),
    .enable      ((state_q == StOn) && !load),
    .tone        (tone)
  );

  assign piezo_d = (state_d == StOn) ? tone : 1'b0;

  // State, selection, cadence counter and output drive registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      cad_cnt_q <= '0;
      piezo_q   <= 1'b0;
      piezo_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cad_cnt_q <= cad_cnt_d;
      piezo_q   <= piezo_d;
      piezo_n_q <= ~piezo_d;
    end
  end

  assign piezo      = piezo_q;
  assign piezo_n    = piezo_n_q;
  assign active_idx = sel_q;
  assign busy       = (state_q != StIdle);

endmodule
